// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU.
// Strobes are decoded from the registered phase state, the opcode and the zero flag.
module cpu_controller #(
    parameter int PHASE_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         opcode,
    input  logic               zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t state_r;
    logic   alu_op_s;
    logic   is_hlt_s;
    logic   is_skz_s;
    logic   is_sto_s;
    logic   is_jmp_s;

    // Opcodes whose operand comes from memory and whose result lands in the accumulator
    function automatic logic is_alu_op(input logic [2:0] op);
        logic res;
        case (op)
            3'b010:  res = 1'b1;
            3'b011:  res = 1'b1;
            3'b100:  res = 1'b1;
            3'b101:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Opcode class decode
    always_comb begin
        alu_op_s = is_alu_op(opcode);
        is_hlt_s = (opcode == OP_HLT);
        is_skz_s = (opcode == OP_SKZ);
        is_sto_s = (opcode == OP_STO);
        is_jmp_s = (opcode == OP_JMP);
    end

    // Phase sequencer; HLT seen at OP_ADDR parks the machine until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= INST_ADDR;
        end else begin
            case (state_r)
                INST_ADDR:  state_r <= INST_FETCH;
                INST_FETCH: state_r <= INST_LOAD;
                INST_LOAD:  state_r <= IDLE;
                IDLE:       state_r <= OP_ADDR;
                OP_ADDR: begin
                    if (is_hlt_s) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= OP_FETCH;
                    end
                end
                OP_FETCH:   state_r <= ALU_OP;
                ALU_OP:     state_r <= STORE;
                STORE:      state_r <= INST_ADDR;
                HALTED:     state_r <= HALTED;
                default:    state_r <= INST_ADDR;
            endcase
        end
    end

    // Strobe decode of the current phase
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = state_r[PHASE_W-1:0];
        case (state_r)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                if (is_hlt_s) begin
                    halt = 1'b1;
                end else begin
                    inc_pc = 1'b1;
                end
            end
            OP_FETCH: begin
                rd = alu_op_s;
            end
            ALU_OP: begin
                rd     = alu_op_s;
                inc_pc = is_skz_s & zero;
                ld_pc  = is_jmp_s;
                data_e = is_sto_s;
            end
            STORE: begin
                rd     = alu_op_s;
                ld_ac  = alu_op_s;
                ld_pc  = is_jmp_s;
                inc_pc = is_jmp_s;
                wr     = is_sto_s;
                data_e = is_sto_s;
            end
            HALTED: begin
                halt  = 1'b1;
                phase = PHASE_W'(3'd4);
            end
            default: begin
                halt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a phase/halt model checked every cycle,
// plus hand-computed per-phase strobe masks for each instruction class.
module tb_cpu_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] opcode = 3'b101;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_phase = 0;
    bit m_halted = 1'b0;

    logic [7:0] msk [8];

    cpu_controller #(.PHASE_W(3)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
    );

    always #5 clock = ~clock;

    // Model state: a phase counter 0..7 and a sticky halted flag
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'b000) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
    end

    // Expected outputs {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,phase}
    function automatic logic [11:0] model_out(int ph, bit halted, logic [2:0] op, logic z);
        bit alu, hlt, skz, sto, jmp;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        if (halted) return {9'b0_0000_0001, 3'd4};
        alu = (op >= 3'd2 && op <= 3'd5);
        hlt = (op == 3'd0);
        skz = (op == 3'd1);
        sto = (op == 3'd6);
        jmp = (op == 3'd7);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ldir = (ph == 2 || ph == 3);
        e_inc  = (ph == 4 && !hlt) || (ph == 6 && skz && z) || (ph == 7 && jmp);
        e_ldpc = (ph >= 6) && jmp;
        e_ldac = (ph == 7) && alu;
        e_wr   = (ph == 7) && sto;
        e_de   = (ph >= 6) && sto;
        e_halt = (ph == 4) && hlt;
        return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, 3'(ph)};
    endfunction

    function automatic logic [11:0] dut_out();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) check("model", 32'(dut_out()), 32'(model_out(m_phase, m_halted, opcode, zero)));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Run one instruction from phase 0, recording each strobe as an 8-bit phase mask
    task automatic run_instr(input logic [2:0] op, input logic z);
        opcode = op;
        zero = z;
        for (int p = 0; p < 8; p++) begin
            check("phase_seq", 32'(phase), p);
            msk[0][p] = sel;    msk[1][p] = rd;    msk[2][p] = ld_ir;  msk[3][p] = inc_pc;
            msk[4][p] = ld_pc;  msk[5][p] = ld_ac; msk[6][p] = wr;     msk[7][p] = data_e;
            tick();
        end
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_state", 32'(dut_out()), 32'({9'b1_0000_0000, 3'd0}));

        run_instr(3'b101, 1'b0);
        check("lda_sel", msk[0], 8'b0000_1111);
        check("lda_rd", msk[1], 8'b1110_1110);
        check("lda_ld_ir", msk[2], 8'b0000_1100);
        check("lda_inc_pc", msk[3], 8'b0001_0000);
        check("lda_ld_ac", msk[5], 8'b1000_0000);
        check("lda_wr", msk[6], 8'b0000_0000);
        check("lda_data_e", msk[7], 8'b0000_0000);

        run_instr(3'b110, 1'b1);
        check("sto_data_e", msk[7], 8'b1100_0000);
        check("sto_wr", msk[6], 8'b1000_0000);
        check("sto_rd", msk[1], 8'b0000_1110);
        check("sto_ld_ac", msk[5], 8'b0000_0000);

        run_instr(3'b111, 1'b0);
        check("jmp_ld_pc", msk[4], 8'b1100_0000);
        check("jmp_inc_pc", msk[3], 8'b1001_0000);
        check("jmp_rd", msk[1], 8'b0000_1110);

        run_instr(3'b001, 1'b1);
        check("skz1_inc_pc", msk[3], 8'b0101_0000);
        run_instr(3'b001, 1'b0);
        check("skz0_inc_pc", msk[3], 8'b0001_0000);

        run_instr(3'b010, 1'b1);
        check("add_ld_ac", msk[5], 8'b1000_0000);
        run_instr(3'b011, 1'b0);
        run_instr(3'b100, 1'b1);
        check("xor_rd", msk[1], 8'b1110_1110);

        // Asynchronous reset in the middle of phase 5
        opcode = 3'b101;
        repeat (5) tick();
        check("pre_reset_phase", 32'(phase), 32'd5);
        #2 reset = 1'b1;
        #1;
        check("midreset_phase", 32'(phase), 32'd0);
        check("midreset_sel", 32'(sel), 32'd1);
        check("midreset_rd_ld_ac", 32'({rd, ld_ac}), 32'd0);
        tick();
        reset = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            tick();
            check("post_reset_phase", 32'(phase), p);
        end
        repeat (4) tick();

        // HLT decided at phase 4, then parked until reset
        opcode = 3'b000;
        repeat (4) tick();
        check("hlt_p4_halt", 32'(halt), 32'd1);
        check("hlt_p4_inc_pc", 32'(inc_pc), 32'd0);
        tick();
        opcode = 3'b010;
        for (int i = 0; i < 20; i++) begin
            zero = i[0];
            tick();
            check("halted_state", 32'(dut_out()), 32'({9'b0_0000_0001, 3'd4}));
        end
        #2 reset = 1'b1;
        #1;
        check("unhalt_halt", 32'(halt), 32'd0);
        check("unhalt_phase", 32'(phase), 32'd0);
        tick();
        reset = 1'b0;
        run_instr(3'b101, 1'b0);
        check("resume_ld_ac", msk[5], 8'b1000_0000);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Eight-phase control sequencer for the 8-bit RISC CPU.
- Consumes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Drives the fetch/execute control strobes: PC mux select, memory read/write, IR load, PC increment/load, accumulator load, data-bus enable and halt.
- It is the consumer side of the opcode/address split produced at instruction load.

Parameters:
- PHASE_W, 3, width of phase counter (fixed 8 phases; not intended to change)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces phase INST_ADDR and clears halt
- opcode  input  3  current instruction opcode from IR (stable from phase 3 to end of instruction)
- zero  input  1  accumulator == 0 flag
- sel  output  1  address mux: 1 = PC, 0 = IR address field
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc  output  1  load PC from IR address field
- ld_ac  output  1  load accumulator from ALU
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  CPU halted (sticky)
- phase  output  3  current phase, for debug/bench

Behaviour:
- Opcode map: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
- ALUOP = ADD | AND | XOR | LDA.
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
- Phase advances 0→7→0 unconditionally, one per clock.
- Exception: in OP_ADDR with opcode == HLT, the next state is HALTED. HALTED is absorbing until reset.
- Outputs are combinational decodes of the registered state, opcode and zero. There is no extra latency.
- Output decode per phase:
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1 if opcode != HLT; halt=1 if opcode == HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = JMP; data_e = STO.
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; inc_pc=JMP; wr=STO; data_e=STO.
  - HALTED: halt=1, all other strobes 0, phase output = 4.
- Unlisted outputs are 0 in every phase.
- Reset (asynchronous, any time, including mid-instruction or while HALTED):
  - State = INST_ADDR immediately, so sel=1 and all other strobes 0, halt=0, phase=0.
  - On reset release, the first rising edge moves to INST_FETCH.
- zero is sampled only in ALU_OP. Changes elsewhere have no effect.
- Opcode changes outside phases 4–7 have no effect on strobes.
- Timing: the opcode value at OP_ADDR decides halt. wr and ld_ac are never both 1. rd and wr are never both 1.
- SKZ with zero=0: no extra inc_pc; only the OP_ADDR increment occurs.

Test Plan:
- Reset mid-phase 5 with opcode=LDA → phase=0, sel=1, rd=ld_ac=0 immediately (before the next edge). After release, phase sequence is 1,2,3,4,…
- opcode=LDA (101), 8 clocks from phase 0:
  - sel=1 in phases 0–3; rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2–3.
  - inc_pc=1 in phase 4 only; ld_ac=1 in phase 7 only.
  - wr=data_e=0 throughout.
- opcode=STO (110) → data_e=1 in phases 6–7, wr=1 in phase 7 only, rd=0 in phases 5–7, ld_ac=0.
- opcode=JMP (111) → ld_pc=1 in phases 6–7, inc_pc=1 in phases 4 and 7, rd=0 in phases 5–7.
- opcode=SKZ (001):
  - zero=1 → inc_pc=1 in phases 4 and 6 (two increments).
  - zero=0 → inc_pc=1 in phase 4 only.
- opcode=HLT (000) at phase 4:
  - halt=1 and inc_pc=0 in phase 4; next edge enters HALTED.
  - halt stays 1, all strobes 0 and phase=4 for 20 clocks despite opcode changing to ADD.
  - Asserting reset → halt=0, phase=0.
